// File: rtl/telemetry_uart_tx.sv
// telemetry_uart_tx: periodically snapshots bumper state and per-window encoder edge counts
// and sends them as an 8N1 UART frame. Define TELEM_CHECKSUM_EN to append an XOR checksum byte.
module telemetry_uart_tx #(
  parameter int         CLKS_PER_BIT = 1666,
  parameter int         FRAME_PERIOD = 1600000,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       WF_CLK,
  input  logic       WF_BUTTON,
  input  logic       enable,
  input  logic [5:0] bump,
  input  logic       motorL_encdr,
  input  logic       motorR_encdr,
  output logic       Tx,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WIN_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
`ifdef TELEM_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(FRAME_PERIOD - 1);
  localparam logic [2:0]       BYTE_LAST = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Edge counters restart on the tick; an edge on the tick itself opens the new window at 1.
  function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic rise, input logic tick);
    logic [7:0] nxt;
    if (tick) begin
      nxt = {7'b0000000, rise};
    end else if (rise && (cnt != 8'hFF)) begin
      nxt = cnt + 8'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

`ifdef TELEM_CHECKSUM_EN
  function automatic logic [7:0] frame_xor(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    return b0 ^ b1 ^ b2 ^ b3;
  endfunction
`endif

  logic [5:0]       bump_s1_q, bump_s2_q;
  logic             enc_l_s1_q, enc_l_s2_q, enc_l_prev_q;
  logic             enc_r_s1_q, enc_r_s2_q, enc_r_prev_q;
  logic [7:0]       cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [5:0]       snap_bump_q, snap_bump_d;
  logic [7:0]       snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic             overrun_q, overrun_d;

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rise_l_s, rise_r_s, tick_s, busy_s, start_s, bit_end_s;
  logic [7:0]       cur_byte_s;

  assign rise_l_s  = enc_l_s2_q & ~enc_l_prev_q;
  assign rise_r_s  = enc_r_s2_q & ~enc_r_prev_q;
  assign tick_s    = (win_q == WIN_LAST);
  assign busy_s    = (state_q != ST_IDLE);
  assign start_s   = tick_s & enable & ~busy_s;
  assign bit_end_s = (bit_cnt_q == BIT_LAST);

  // Window timer, edge counters, snapshot and sticky overrun next-state.
  always_comb begin
    win_d       = tick_s ? '0 : (win_q + WIN_W'(1'b1));
    cnt_l_d     = cnt_next(cnt_l_q, rise_l_s, tick_s);
    cnt_r_d     = cnt_next(cnt_r_q, rise_r_s, tick_s);
    snap_bump_d = snap_bump_q;
    snap_l_d    = snap_l_q;
    snap_r_d    = snap_r_q;
    overrun_d   = overrun_q;
    if (tick_s && !busy_s) begin
      snap_bump_d = bump_s2_q;
      snap_l_d    = cnt_l_q;
      snap_r_d    = cnt_r_q;
    end else if (tick_s && busy_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // UART framing FSM: next state and bit/byte position.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d    = ST_START;
          bit_cnt_d  = '0;
          byte_idx_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1'b1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1'b1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          bit_cnt_d = '0;
          if (byte_idx_q == BYTE_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_START;
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte selected by the upcoming byte index; the snapshot is stable before any data bit.
  always_comb begin
    cur_byte_s = HEADER;
    case (byte_idx_d)
      3'd0:    cur_byte_s = HEADER;
      3'd1:    cur_byte_s = {2'b00, snap_bump_q};
      3'd2:    cur_byte_s = snap_l_q;
      3'd3:    cur_byte_s = snap_r_q;
`ifdef TELEM_CHECKSUM_EN
      3'd4:    cur_byte_s = frame_xor(HEADER, {2'b00, snap_bump_q}, snap_l_q, snap_r_q);
`endif
      default: cur_byte_s = 8'hFF;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with the FSM.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (byte_idx_d == BYTE_LAST) && (bit_cnt_d == BIT_LAST);
    case (state_d)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = cur_byte_s[bit_idx_d];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Input synchronisers and encoder edge history.
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      bump_s1_q    <= 6'd0;
      bump_s2_q    <= 6'd0;
      enc_l_s1_q   <= 1'b0;
      enc_l_s2_q   <= 1'b0;
      enc_l_prev_q <= 1'b0;
      enc_r_s1_q   <= 1'b0;
      enc_r_s2_q   <= 1'b0;
      enc_r_prev_q <= 1'b0;
    end else begin
      bump_s1_q    <= bump;
      bump_s2_q    <= bump_s1_q;
      enc_l_s1_q   <= motorL_encdr;
      enc_l_s2_q   <= enc_l_s1_q;
      enc_l_prev_q <= enc_l_s2_q;
      enc_r_s1_q   <= motorR_encdr;
      enc_r_s2_q   <= enc_r_s1_q;
      enc_r_prev_q <= enc_r_s2_q;
    end
  end

  // Window, counter, snapshot and overrun state.
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      win_q       <= '0;
      cnt_l_q     <= 8'd0;
      cnt_r_q     <= 8'd0;
      snap_bump_q <= 6'd0;
      snap_l_q    <= 8'd0;
      snap_r_q    <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      win_q       <= win_d;
      cnt_l_q     <= cnt_l_d;
      cnt_r_q     <= cnt_r_d;
      snap_bump_q <= snap_bump_d;
      snap_l_q    <= snap_l_d;
      snap_r_q    <= snap_r_d;
      overrun_q   <= overrun_d;
    end
  end

  // FSM state and registered line outputs.
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// Scoreboard bench for telemetry_uart_tx: three instances (window 400, 100, 800 cycles),
// a UART decoder per instance pops expected bytes queued by the directed stimulus.
module tb_telemetry_uart_tx;

  localparam int CPB = 4;
`ifdef TELEM_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FB    = 10 * CPB;
  localparam int FL    = NB * FB;
  localparam int B_GAP = ((FL / 100) + 1) * 100;
  localparam int B_S2  = 100 + B_GAP;

  logic       clk;
  logic [2:0] rst_v, en_v, encl_v, encr_v;
  logic [5:0] bump;
  wire  [2:0] tx_w, busy_w, fd_w, ovr_w;

  int n_checks = 0;
  int n_errors = 0;
  int fd_a = 0, fd_b = 0, fd_c = 0;
  logic [7:0] exp_q [3][$];

  telemetry_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_PERIOD(400), .HEADER(8'hA5)) u_a (
    .WF_CLK(clk), .WF_BUTTON(rst_v[0]), .enable(en_v[0]), .bump(bump),
    .motorL_encdr(encl_v[0]), .motorR_encdr(encr_v[0]),
    .Tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]), .overrun(ovr_w[0]));

  telemetry_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_PERIOD(100), .HEADER(8'hA5)) u_b (
    .WF_CLK(clk), .WF_BUTTON(rst_v[1]), .enable(en_v[1]), .bump(6'b000000),
    .motorL_encdr(encl_v[1]), .motorR_encdr(encr_v[1]),
    .Tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]), .overrun(ovr_w[1]));

  telemetry_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_PERIOD(800), .HEADER(8'hA5)) u_c (
    .WF_CLK(clk), .WF_BUTTON(rst_v[2]), .enable(en_v[2]), .bump(bump),
    .motorL_encdr(encl_v[2]), .motorR_encdr(encr_v[2]),
    .Tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]), .overrun(ovr_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (fd_w[0]) fd_a <= fd_a + 1;
    if (fd_w[1]) fd_b <= fd_b + 1;
    if (fd_w[2]) fd_c <= fd_c + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Cycle t = negedge number t after the common reset release at time 10.
  task automatic at_cyc(input int t);
    longint tt;
    tt = 64'd10 + 64'd10 * longint'(t);
    if ($time < tt) #(tt - $time);
  endtask

  task automatic push_frame(input int g, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3);
    exp_q[g].push_back(8'hA5);
    exp_q[g].push_back(b1);
    exp_q[g].push_back(b2);
    exp_q[g].push_back(b3);
`ifdef TELEM_CHECKSUM_EN
    exp_q[g].push_back(8'hA5 ^ b1 ^ b2 ^ b3);
`endif
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin : mon
      logic [FB-1:0] s;
      logic [7:0]    d;
      logic [7:0]    e;
      logic          ok;
      logic          disc;
      forever begin
        @(negedge clk);
        if (tx_w[g] == 1'b0 && rst_v[g] == 1'b1) begin
          s    = '0;
          disc = 1'b0;
          for (int k = 1; k < FB; k++) begin
            @(negedge clk);
            s[k] = tx_w[g];
            if (rst_v[g] == 1'b0) disc = 1'b1;
          end
          if (!disc) begin
            ok = 1'b1;
            for (int b = 0; b < 10; b++)
              for (int k = 1; k < CPB; k++)
                if (s[b*CPB+k] != s[b*CPB]) ok = 1'b0;
            for (int i = 0; i < 8; i++) d[i] = s[(i+1)*CPB];
            chk($sformatf("dut%0d_bit_width", g), 32'(ok), 32'd1);
            chk($sformatf("dut%0d_stop_bit", g), 32'(s[9*CPB]), 32'd1);
            if (exp_q[g].size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL dut%0d_unexpected_byte: got %02h expected none", g, d);
            end else begin
              e = exp_q[g].pop_front();
              chk($sformatf("dut%0d_byte", g), 32'(d), 32'(e));
            end
          end
        end
      end
    end
  end

  initial begin
    rst_v  = 3'b111;
    en_v   = 3'b111;
    encl_v = 3'b000;
    encr_v = 3'b000;
    bump   = 6'b000000;
    #2 rst_v = 3'b000;
    push_frame(0, 8'h00, 8'h00, 8'h00);
    push_frame(1, 8'h00, 8'h00, 8'h00);
    push_frame(1, 8'h00, 8'h00, 8'h00);
    push_frame(2, 8'h29, 8'hFF, 8'h00);
    at_cyc(0);
    rst_v = 3'b111;
    fork
      begin : seq_a
        for (int c = 1; c < 400; c++) begin
          at_cyc(c);
          chk("a_idle_tx_busy_ovr", 32'({tx_w[0], busy_w[0], ovr_w[0]}), 32'b100);
        end
        at_cyc(400);
        chk("a_first_start_tx", 32'(tx_w[0]), 32'd0);
        chk("a_first_busy", 32'(busy_w[0]), 32'd1);
        at_cyc(410);
        bump = 6'b101001;
        for (int i = 0; i < 7; i++) begin
          encl_v[0] = 1'b1;
          if (i < 3) encr_v[0] = 1'b1;
          repeat (4) @(negedge clk);
          encl_v[0] = 1'b0;
          encr_v[0] = 1'b0;
          repeat (4) @(negedge clk);
        end
        push_frame(0, 8'h29, 8'h07, 8'h03);
        at_cyc(400 + FL - 2);
        chk("a_fd_early", 32'(fd_w[0]), 32'd0);
        at_cyc(400 + FL - 1);
        chk("a_fd_last_stop", 32'({fd_w[0], busy_w[0], tx_w[0]}), 32'b111);
        at_cyc(400 + FL);
        chk("a_after_frame", 32'({fd_w[0], busy_w[0], tx_w[0]}), 32'b001);
        at_cyc(1197);
        encl_v[0] = 1'b1;
        push_frame(0, 8'h29, 8'h00, 8'h00);
        push_frame(0, 8'h29, 8'h01, 8'h00);
        at_cyc(1300);
        encl_v[0] = 1'b0;
        at_cyc(1900);
        en_v[0] = 1'b0;
        for (int c = 1900; c < 2300; c++) begin
          at_cyc(c);
          chk("a_disabled_tx_busy", 32'({tx_w[0], busy_w[0]}), 32'b10);
        end
        at_cyc(2300);
        en_v[0] = 1'b1;
        push_frame(0, 8'h29, 8'h00, 8'h00);
        at_cyc(2399);
        chk("a_pre_tick_tx", 32'(tx_w[0]), 32'd1);
        at_cyc(2400);
        chk("a_start_after_enable", 32'({tx_w[0], busy_w[0]}), 32'b01);
        at_cyc(2410);
        en_v[0] = 1'b0;
        at_cyc(2400 + FL - 1);
        chk("a_en_drop_completes", 32'({fd_w[0], busy_w[0]}), 32'b11);
        at_cyc(2400 + FL);
        chk("a_en_drop_idle", 32'(busy_w[0]), 32'd0);
        at_cyc(2700);
        en_v[0] = 1'b1;
        chk("a_no_overrun", 32'(ovr_w[0]), 32'd0);
        push_frame(0, 8'h29, 8'h00, 8'h00);
        at_cyc(2857);
        #1 rst_v[0] = 1'b0;
        #1;
        chk("a_async_reset", 32'({tx_w[0], busy_w[0], fd_w[0], ovr_w[0]}), 32'b1000);
        exp_q[0].delete();
        at_cyc(2870);
        rst_v[0] = 1'b1;
        push_frame(0, 8'h29, 8'h00, 8'h00);
        at_cyc(2870 + 399);
        chk("a_post_reset_idle", 32'({tx_w[0], busy_w[0]}), 32'b10);
        at_cyc(2870 + 400);
        chk("a_post_reset_start", 32'({tx_w[0], busy_w[0]}), 32'b01);
        at_cyc(3270 + FL + 2);
        chk("a_frame_done_count", 32'(fd_a), 32'd6);
        chk("a_final_idle", 32'({tx_w[0], busy_w[0], ovr_w[0]}), 32'b100);
      end
      begin : seq_b
        at_cyc(99);
        chk("b_pre_tick", 32'({tx_w[1], busy_w[1]}), 32'b10);
        at_cyc(100);
        chk("b_start", 32'({tx_w[1], busy_w[1]}), 32'b01);
        at_cyc(110);
        for (int i = 0; i < 5; i++) begin
          encl_v[1] = 1'b1;
          encr_v[1] = 1'b1;
          repeat (4) @(negedge clk);
          encl_v[1] = 1'b0;
          encr_v[1] = 1'b0;
          repeat (4) @(negedge clk);
        end
        at_cyc(199);
        chk("b_overrun_before", 32'(ovr_w[1]), 32'd0);
        at_cyc(200);
        chk("b_overrun_set", 32'({ovr_w[1], busy_w[1]}), 32'b11);
        at_cyc(B_S2 - 1);
        chk("b_skip_idle", 32'({tx_w[1], busy_w[1]}), 32'b10);
        at_cyc(B_S2);
        chk("b_second_start", 32'({tx_w[1], busy_w[1]}), 32'b01);
        at_cyc(B_S2 + 10);
        en_v[1] = 1'b0;
        at_cyc(B_S2 + FL + 2);
        chk("b_end_state", 32'({tx_w[1], busy_w[1], ovr_w[1]}), 32'b101);
        chk("b_frame_done_count", 32'(fd_b), 32'd2);
      end
      begin : seq_c
        at_cyc(10);
        for (int k = 0; k < 600; k++) begin
          encl_v[2] = ~encl_v[2];
          @(negedge clk);
        end
        at_cyc(800);
        chk("c_start", 32'(tx_w[2]), 32'd0);
        at_cyc(810);
        en_v[2] = 1'b0;
        at_cyc(800 + FL + 2);
        chk("c_frame_done_count", 32'(fd_c), 32'd1);
        chk("c_idle", 32'({busy_w[2], ovr_w[2]}), 32'b00);
      end
    join
    at_cyc(3500);
    for (int g = 0; g < 3; g++)
      chk($sformatf("dut%0d_bytes_left", g), 32'(exp_q[g].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
